// File: rtl/float_pkg.sv
// Shared types and constants for the iterative float divider.
// FLOAT_DIVIDER_ROUND_EN adds one extra quotient bit (guard) for rounding.
package float_pkg;

  localparam int FLOAT_SIZE    = 32;
  localparam int EXPONENT_SIZE = 8;
  localparam int MANTISSA_SIZE = 23;
  localparam int BIAS          = 127;

`ifdef FLOAT_DIVIDER_ROUND_EN
  localparam int EXTRA_STEPS = 1;
`else
  localparam int EXTRA_STEPS = 0;
`endif

  // Quotient bits produced by the restoring loop, one per DIVIDE cycle.
  localparam int QUOT_WIDTH = MANTISSA_SIZE + 2 + EXTRA_STEPS;
  // Partial remainder needs one bit above the divisor for the shifted value.
  localparam int REM_WIDTH  = MANTISSA_SIZE + 2;
  localparam int ITER_WIDTH = $clog2(MANTISSA_SIZE + 3);
  // Signed exponent with headroom for overflow and underflow detection.
  localparam int EXP_WIDTH  = EXPONENT_SIZE + 2;

  localparam logic [ITER_WIDTH-1:0]       LAST_ITER = ITER_WIDTH'(QUOT_WIDTH - 1);
  localparam logic signed [EXP_WIDTH-1:0] EXP_BIAS  = EXP_WIDTH'(BIAS);
  localparam logic signed [EXP_WIDTH-1:0] EXP_MAX   = EXP_WIDTH'((2 ** EXPONENT_SIZE) - 2);
  localparam logic signed [EXP_WIDTH-1:0] EXP_ONE   = EXP_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } state_t;

  typedef struct packed {
    logic                     sign;
    logic [EXPONENT_SIZE-1:0] exponent;
    logic [MANTISSA_SIZE-1:0] mantissa;
  } float_t;

  function automatic float_t unpack_float(input logic [FLOAT_SIZE-1:0] f);
    float_t r;
    r.sign     = f[FLOAT_SIZE-1];
    r.exponent = f[FLOAT_SIZE-2:MANTISSA_SIZE];
    r.mantissa = f[MANTISSA_SIZE-1:0];
    return r;
  endfunction

endpackage

// File: rtl/mantissa_div_step.sv
// One radix-2 restoring division step: subtract, keep or restore, shift.
module mantissa_div_step
  import float_pkg::*;
(
  input  logic [REM_WIDTH-1:0] rem,
  input  logic [REM_WIDTH-1:0] divisor,
  output logic [REM_WIDTH-1:0] next_rem,
  output logic                 q_bit
);

  logic [REM_WIDTH:0]   trial;
  logic [REM_WIDTH-1:0] kept;

  // The restored remainder is always below the divisor, so its top bit is free for the shift.
  always_comb begin
    trial    = {1'b0, rem} - {1'b0, divisor};
    q_bit    = ~trial[REM_WIDTH];
    kept     = q_bit ? trial[REM_WIDTH-1:0] : rem;
    next_rem = {kept[REM_WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/float_divider.sv
// Iterative float divider (a / b), one quotient bit per cycle, start/done handshake.
// Define FLOAT_DIVIDER_ROUND_EN for round-to-nearest-even; otherwise truncates.
module float_divider
  import float_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FLOAT_SIZE-1:0] a,
  input  logic [FLOAT_SIZE-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [FLOAT_SIZE-1:0] out,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  inexact
);

  state_t state, next_state;

  float_t fa, fb;

  logic                        sign_r;
  logic signed [EXP_WIDTH-1:0] exp_r;
  logic [REM_WIDTH-1:0]        rem_r;
  logic [MANTISSA_SIZE:0]      divisor_r;
  logic [QUOT_WIDTH-1:0]       q_r;
  logic [ITER_WIDTH-1:0]       iter_r;

  logic [REM_WIDTH-1:0]        step_rem;
  logic                        step_q;

  logic signed [EXP_WIDTH-1:0] final_exp;
  logic [MANTISSA_SIZE-1:0]    final_man;
  logic                        final_inexact;
  logic                        rem_nz;
`ifdef FLOAT_DIVIDER_ROUND_EN
  logic [MANTISSA_SIZE-1:0]    man_trunc;
  logic [MANTISSA_SIZE:0]      man_inc;
  logic                        guard;
  logic                        sticky;
  logic                        round_up;
`else
  logic                        extra;
`endif

  // Split the operands into their fields.
  always_comb begin
    fa = unpack_float(a);
    fb = unpack_float(b);
  end

  mantissa_div_step u_step (
    .rem      (rem_r),
    .divisor  ({1'b0, divisor_r}),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:    if (start) next_state = DIVIDE;
      DIVIDE: begin
        busy = 1'b1;
        if (iter_r == LAST_ITER) next_state = NORM;
      end
      NORM: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Normalise the quotient into a mantissa and final exponent and derive inexact.
  always_comb begin
    rem_nz = |rem_r;
`ifdef FLOAT_DIVIDER_ROUND_EN
    if (q_r[QUOT_WIDTH-1]) begin
      man_trunc = q_r[MANTISSA_SIZE+1:2];
      guard     = q_r[1];
      sticky    = rem_nz | q_r[0];
      final_exp = exp_r;
    end else begin
      man_trunc = q_r[MANTISSA_SIZE:1];
      guard     = q_r[0];
      sticky    = rem_nz;
      final_exp = exp_r - EXP_ONE;
    end
    round_up = guard & (sticky | man_trunc[0]);
    man_inc  = {1'b0, man_trunc} + {{MANTISSA_SIZE{1'b0}}, round_up};
    if (man_inc[MANTISSA_SIZE]) begin
      final_man = '0;
      final_exp = final_exp + EXP_ONE;
    end else begin
      final_man = man_inc[MANTISSA_SIZE-1:0];
    end
    final_inexact = guard | sticky;
`else
    if (q_r[QUOT_WIDTH-1]) begin
      final_man = q_r[MANTISSA_SIZE:1];
      extra     = q_r[0];
      final_exp = exp_r;
    end else begin
      final_man = q_r[MANTISSA_SIZE-1:0];
      extra     = 1'b0;
      final_exp = exp_r - EXP_ONE;
    end
    final_inexact = rem_nz | extra;
`endif
  end

  // Operand capture, iterative division and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sign_r    <= 1'b0;
      exp_r     <= '0;
      rem_r     <= '0;
      divisor_r <= '0;
      q_r       <= '0;
      iter_r    <= '0;
      out       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign_r    <= fa.sign ^ fb.sign;
            exp_r     <= $signed({2'b00, fa.exponent}) - $signed({2'b00, fb.exponent}) + EXP_BIAS;
            rem_r     <= {2'b01, fa.mantissa};
            divisor_r <= {1'b1, fb.mantissa};
            q_r       <= '0;
            iter_r    <= '0;
          end
        end
        DIVIDE: begin
          rem_r  <= step_rem;
          q_r    <= {q_r[QUOT_WIDTH-2:0], step_q};
          iter_r <= iter_r + ITER_WIDTH'(1);
        end
        NORM: begin
          out       <= {sign_r, final_exp[EXPONENT_SIZE-1:0], final_man};
          overflow  <= final_exp > EXP_MAX;
          underflow <= final_exp < EXP_ONE;
          inexact   <= final_inexact;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_divider.sv
// Self-checking bench for float_divider: arithmetic reference model, scoreboard and directed vectors.
// Honours FLOAT_DIVIDER_ROUND_EN for expected latency and rounding.
module tb_float_divider;

`ifdef FLOAT_DIVIDER_ROUND_EN
  localparam int LATENCY = 28;
`else
  localparam int LATENCY = 27;
`endif

  typedef struct {
    logic [31:0] out;
    logic        ov;
    logic        un;
    logic        ix;
  } result_t;

  typedef struct {
    result_t res;
    int      period;
  } expect_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  int      cyc = 0;
  int      vectors = 0;
  int      miscompares = 0;
  int      dones_seen = 0;
  bit      hold_valid = 0;
  expect_t pending[$];
  expect_t cur;
  result_t last;
  result_t pin;

  float_divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Quotient from exact integer division of the significands, then normalise/round.
  function automatic result_t model(input logic [31:0] x, input logic [31:0] y);
    result_t r;
    longint  na, nb, num, quo, mant;
    int      e;
    bit      guard, sticky;
    na = longint'(x[22:0]) + (longint'(1) << 23);
    nb = longint'(y[22:0]) + (longint'(1) << 23);
    e  = int'(x[30:23]) - int'(y[30:23]) + 127;
    guard = 0;
`ifdef FLOAT_DIVIDER_ROUND_EN
    num    = na << 25;
    quo    = num / nb;
    sticky = (num % nb) != 0;
    if (quo >= (longint'(1) << 25)) begin
      mant   = (quo >> 2) % (longint'(1) << 23);
      guard  = ((quo >> 1) % 2) != 0;
      sticky = sticky || ((quo % 2) != 0);
    end else begin
      mant  = (quo >> 1) % (longint'(1) << 23);
      guard = (quo % 2) != 0;
      e     = e - 1;
    end
    if (guard && (sticky || (mant % 2) != 0)) begin
      mant = mant + 1;
      if (mant == (longint'(1) << 23)) begin
        mant = 0;
        e    = e + 1;
      end
    end
`else
    num    = na << 24;
    quo    = num / nb;
    sticky = (num % nb) != 0;
    if (quo >= (longint'(1) << 24)) begin
      mant   = (quo >> 1) % (longint'(1) << 23);
      sticky = sticky || ((quo % 2) != 0);
    end else begin
      mant = quo % (longint'(1) << 23);
      e    = e - 1;
    end
`endif
    r.ix  = guard | sticky;
    r.ov  = e > 254;
    r.un  = e < 1;
    r.out = {x[31] ^ y[31], 8'(e), 23'(mant)};
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h (period %0d)", name, act, req, cyc);
    end
  endtask

  task automatic pushExpect(input logic [31:0] x, input logic [31:0] y, input int period);
    expect_t e;
    e.res    = model(x, y);
    e.period = period;
    pending.push_back(e);
  endtask

  task automatic waitDones(input int target);
    int n = 0;
    while (dones_seen < target && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    vectors++;
    if (dones_seen < target) begin
      miscompares++;
      $display("[TB] FAIL done_timeout: got %0d done pulses, required %0d", dones_seen, target);
      pending.delete();
    end
  endtask

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
    int target;
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    pushExpect(x, y, cyc);
    target = dones_seen + 1;
    @(negedge clk);
    start = 1'b0;
    waitDones(target);
  endtask

  // Scoreboard: every done pulse is checked against the model; idle cycles must hold the last result.
  always @(negedge clk) begin
    if (done) begin
      dones_seen++;
      if (pending.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: got done=1 at period %0d, required 0", cyc);
      end else begin
        cur = pending.pop_front();
        checkOutput("out", out, cur.res.out);
        checkOutput("overflow", overflow, cur.res.ov);
        checkOutput("underflow", underflow, cur.res.un);
        checkOutput("inexact", inexact, cur.res.ix);
        checkOutput("latency", cyc - cur.period, LATENCY);
        last       = cur.res;
        hold_valid = 1;
      end
    end else if (hold_valid && !busy) begin
      checkOutput("hold_out", out, last.out);
      checkOutput("hold_flags", {overflow, underflow, inexact}, {last.ov, last.un, last.ix});
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p;
    int target;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_out", out, 0);
    checkOutput("reset_flags", {overflow, underflow, inexact}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Hand-computed values that pin the reference model.
    pin = model(32'h40C00000, 32'h40000000);
    checkOutput("model_6div2", {pin.out, pin.ov, pin.un, pin.ix}, {32'h40400000, 3'b000});
    pin = model(32'hBFC00000, 32'h3F000000);
    checkOutput("model_neg", {pin.out, pin.ix}, {32'hC0400000, 1'b0});
    pin = model(32'h7F000000, 32'h00800000);
    checkOutput("model_ovf", {pin.out, pin.ov, pin.un}, {32'h3E000000, 2'b10});
    pin = model(32'h00800000, 32'h7F000000);
    checkOutput("model_unf", {pin.out, pin.ov, pin.un}, {32'h41000000, 2'b01});
`ifdef FLOAT_DIVIDER_ROUND_EN
    pin = model(32'h3F800000, 32'h40400000);
    checkOutput("model_third", {pin.out, pin.ix}, {32'h3EAAAAAB, 1'b1});
    pin = model(32'h3F800000, 32'h3FC00000);
    checkOutput("model_2thirds", {pin.out, pin.ix}, {32'h3F2AAAAB, 1'b1});
`else
    pin = model(32'h3F800000, 32'h40400000);
    checkOutput("model_third", {pin.out, pin.ix}, {32'h3EAAAAAA, 1'b1});
    pin = model(32'h3F800000, 32'h3FC00000);
    checkOutput("model_2thirds", {pin.out, pin.ix}, {32'h3F2AAAAA, 1'b1});
`endif

    // Directed operations.
    applyStimulus(32'h40C00000, 32'h40000000);
    applyStimulus(32'h3F800000, 32'h40400000);
    applyStimulus(32'hBFC00000, 32'h3F000000);
    applyStimulus(32'h3F800000, 32'h3FC00000);
    applyStimulus(32'h7F000000, 32'h00800000);
    applyStimulus(32'h00800000, 32'h7F000000);
    applyStimulus(32'h41200000, 32'hC0800000);
    applyStimulus(32'h3F800000, 32'h3F800000);
    applyStimulus(32'h40490FDB, 32'h402DF854);
    applyStimulus(32'hC2F6E979, 32'hC1A4CCCD);

    // Handshake: a second start while busy is ignored; busy/done timing checked each cycle.
    @(negedge clk);
    a     = 32'h40C00000;
    b     = 32'h40000000;
    start = 1'b1;
    p     = cyc;
    pushExpect(32'h40C00000, 32'h40000000, p);
    for (int k = 1; k <= LATENCY + 2; k++) begin
      @(negedge clk);
      start = (k == 5);
      if (k == 5) begin
        a = 32'h3F800000;
        b = 32'h40400000;
      end
      #1;
      checkOutput($sformatf("hs_busy_%0d", k), busy, (k <= LATENCY - 1));
      checkOutput($sformatf("hs_done_%0d", k), done, (k == LATENCY));
    end
    start = 1'b0;

    // Reset mid-divide aborts without a done pulse.
    @(negedge clk);
    a     = 32'h3F800000;
    b     = 32'h40400000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk);
    reset      = 1'b1;
    hold_valid = 0;
    pending.delete();
    @(negedge clk);
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_out", out, 0);
    checkOutput("abort_flags", {overflow, underflow, inexact}, 0);
    reset = 1'b0;
    for (int k = 0; k < LATENCY + 3; k++) begin
      @(negedge clk);
      #1;
      checkOutput("abort_no_done", done, 0);
    end
    applyStimulus(32'h40C00000, 32'h40000000);

    // Start held high: the second operation is accepted on the first idle cycle after DONE.
    @(negedge clk);
    a      = 32'h3F800000;
    b      = 32'h3FC00000;
    start  = 1'b1;
    p      = cyc;
    target = dones_seen + 2;
    pushExpect(32'h3F800000, 32'h3FC00000, p);
    pushExpect(32'h41200000, 32'hC0800000, p + LATENCY + 1);
    @(negedge clk);
    a = 32'h41200000;
    b = 32'hC0800000;
    repeat (LATENCY + 1) @(negedge clk);
    start = 1'b0;
    waitDones(target);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
